// File: rtl/move_stepper.sv
// move_stepper: paced step-strobe transmitter for the four player position counters.
// Optional abort support is enabled by defining MOVE_STEPPER_ABORT_EN.
module move_stepper #(
    parameter int BOARD_LEN = 24,
    parameter int STEP_GAP  = 4,
    parameter int POS_W     = 5
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             start,
    input  logic [1:0]       player,
    input  logic [2:0]       steps,
    input  logic [POS_W-1:0] pos_in,
`ifdef MOVE_STEPPER_ABORT_EN
    input  logic             abort,
    output logic             aborted,
`endif
    output logic             ready,
    output logic             busy,
    output logic             step_d,
    output logic [3:0]       p_da,
    output logic [2:0]       remaining,
    output logic [POS_W-1:0] target_pos,
    output logic             done
);

    typedef enum logic [1:0] {
        IDLE,
        PULSE,
        GAP,
        DONE
    } state_t;

    localparam logic [3:0]   GAP_LOAD = 4'(STEP_GAP - 2);
    localparam logic [POS_W:0] BOARD  = (POS_W+1)'(BOARD_LEN);

    state_t           state;
    state_t           state_next;
    logic [1:0]       player_q;
    logic [2:0]       rem_q;
    logic [3:0]       gap_q;
    logic [POS_W-1:0] tgt_q;
    logic [POS_W:0]   sum;
    logic [POS_W-1:0] tgt_next;
    logic             abort_req;

`ifdef MOVE_STEPPER_ABORT_EN
    logic aborted_q;

    assign abort_req = abort;
    assign aborted   = aborted_q;

    // Flag an early finish on the way into DONE; it lives for the DONE cycle only.
    always_ff @(posedge clk) begin
        if (rst) begin
            aborted_q <= 1'b0;
        end else if (abort && (state == PULSE || state == GAP)) begin
            aborted_q <= 1'b1;
        end else begin
            aborted_q <= 1'b0;
        end
    end
`else
    assign abort_req = 1'b0;
`endif

    // Landing tile: single conditional subtract handles the one possible wrap.
    always_comb begin
        sum = {1'b0, pos_in} + (POS_W+1)'(steps);
        if (sum >= BOARD) begin
            tgt_next = POS_W'(sum - BOARD);
        end else begin
            tgt_next = POS_W'(sum);
        end
    end

    // State register.
    always_ff @(posedge clk) begin
        if (rst) begin
            state <= IDLE;
        end else begin
            state <= state_next;
        end
    end

    // Next-state logic: pulse, wait out the gap, repeat until the count is spent.
    always_comb begin
        state_next = state;
        unique case (state)
            IDLE: begin
                if (start) begin
                    state_next = (steps == 3'd0) ? DONE : PULSE;
                end
            end
            PULSE: begin
                if (rem_q == 3'd1 || abort_req) begin
                    state_next = DONE;
                end else begin
                    state_next = GAP;
                end
            end
            GAP: begin
                if (abort_req) begin
                    state_next = DONE;
                end else if (gap_q == 4'd0) begin
                    state_next = PULSE;
                end
            end
            DONE: begin
                state_next = IDLE;
            end
        endcase
    end

    // Command latch, step countdown and gap pacing counter.
    always_ff @(posedge clk) begin
        if (rst) begin
            player_q <= 2'd0;
            rem_q    <= 3'd0;
            gap_q    <= 4'd0;
            tgt_q    <= '0;
        end else begin
            case (state)
                IDLE: begin
                    if (start) begin
                        player_q <= player;
                        rem_q    <= steps;
                        tgt_q    <= tgt_next;
                    end
                end
                PULSE: begin
                    rem_q <= rem_q - 3'd1;
                    gap_q <= GAP_LOAD;
                end
                GAP: begin
                    if (gap_q != 4'd0) begin
                        gap_q <= gap_q - 4'd1;
                    end
                end
                default: begin
                end
            endcase
        end
    end

    assign ready      = (state == IDLE);
    assign busy       = (state != IDLE);
    assign step_d     = (state == PULSE);
    assign p_da       = step_d ? (4'b0001 << player_q) : 4'b0000;
    assign remaining  = rem_q;
    assign target_pos = tgt_q;
    assign done       = (state == DONE);

endmodule

// File: doc/move_stepper.md
Name: move_stepper

Overview:
- Transmit side of the per-player step-strobe interface (`D` plus one-hot player-active) that drives the four player position counters.
- Accepts a move command: player index and step count.
- Emits the matching number of single-cycle step pulses, paced STEP_GAP cycles apart, to the selected player's counter.
- Reports the landing tile (computed at command time) and signals completion.

Parameters:
- BOARD_LEN, 24, number of board tiles; positions run 0..BOARD_LEN-1 and wrap.
- STEP_GAP, 4, cycles from one step pulse to the next; legal range 2..15.
- POS_W, 5, width of position values; must satisfy 2^POS_W >= BOARD_LEN+7.

Ports:
- clk  input  1  system clock; all logic on rising edge.
- rst  input  1  synchronous, active-high reset.
- start  input  1  move command strobe; sampled only when ready=1.
- player  input  2  player index 0..3 for the command.
- steps  input  3  steps to move, 0..7.
- pos_in  input  POS_W  current position of the selected player, read from its counter; sampled with start.
- ready  output  1  high in IDLE; a command is accepted on this cycle.
- busy  output  1  high from the cycle after acceptance until DONE completes.
- step_d  output  1  step strobe, one cycle per step; drives the counter `D` inputs.
- p_da  output  4  one-hot player-active; bit[player] high only while step_d=1, otherwise 0.
- remaining  output  3  steps not yet pulsed.
- target_pos  output  POS_W  landing tile, latched at acceptance.
- done  output  1  one-cycle completion strobe.

Behaviour:
- Reset values (rst=1 at an edge): state IDLE; ready=1; busy=0; step_d=0; p_da=0; remaining=0; target_pos=0; done=0; gap counter=0.
  - Reset mid-move takes effect on that same edge: no further pulses, done is not issued.
- States: IDLE, PULSE, GAP, DONE.
- IDLE, start=1 at edge k:
  - Latch player and steps; remaining <= steps.
  - target_pos <= pos_in+steps, minus BOARD_LEN if the sum >= BOARD_LEN. Unsigned sum is POS_W+1 bits wide, so max 23+7=30 -> 6.
  - If steps=0: go to DONE (done=1 during cycle k+1, no pulses).
  - Otherwise go to PULSE.
- PULSE, one cycle:
  - step_d=1; p_da=1<<player; remaining decrements at the end of the cycle.
  - If remaining was 1: go to DONE.
  - Otherwise go to GAP, with gap counter loaded to STEP_GAP-2.
- GAP:
  - step_d=0, p_da=0.
  - Decrement the gap counter; go to PULSE when it reads 0.
  - Pulse period is exactly STEP_GAP cycles.
- DONE, one cycle: done=1, busy=1, then IDLE.
- Latency: first pulse in cycle k+1; last pulse in cycle k+1+(steps-1)*STEP_GAP; done the cycle after the last pulse.
- start while not in IDLE is ignored and has no side effects. player, steps and pos_in are don't-care outside the acceptance cycle.
- Board wrap is performed by the receiving counter. target_pos is informational, for catch/match logic.
- Never more than one p_da bit set. step_d and p_da always assert together.

Optional Feature:
- Macro: MOVE_STEPPER_ABORT_EN.
- Defined: adds input `abort` (1 bit) and output `aborted` (1 bit, reset 0).
  - abort=1 at an edge in GAP: go directly to DONE.
  - abort=1 at an edge in PULSE: the current pulse completes, then go to DONE.
  - In both cases aborted=1 alongside done for that DONE cycle only.
  - remaining holds the untaken step count through DONE.
  - target_pos is not corrected.
  - abort in IDLE or DONE is ignored.
- Undefined: no abort port; every accepted move runs to completion.

Test Plan:
- Reset then idle -> ready=1, busy=0, step_d=0, p_da=4'b0000, target_pos=0, done=0.
- start, player=2, steps=3, pos_in=5, STEP_GAP=4, accepted at edge k:
  - step_d/p_da=4'b0100 in cycles k+1, k+5, k+9.
  - done at k+10; target_pos=8; remaining 3->2->1->0.
- player=0, steps=7, pos_in=20 -> target_pos=3; 7 pulses on p_da=4'b0001; done one cycle after the 7th pulse.
- steps=0 -> no step_d pulses; done=1 at k+1; ready=1 at k+2.
- start re-asserted with player=1 while busy -> ignored; pulses remain on the original player; rst asserted between pulses 1 and 2 -> no further pulses, no done, all outputs at reset values.
- MOVE_STEPPER_ABORT_EN defined; steps=5, abort asserted during the GAP after the 2nd pulse:
  - Exactly 2 pulses.
  - Next cycle done=1, aborted=1, remaining=3.
